tick_pulse_gen: RTL and testbench
=================================

Name: tick_pulse_gen

Overview:
- Programmable timer that produces the single-cycle `tick` strobe consumed by the LED pattern logic downstream.
- A prescaler divides `clk`. A down-counter then counts prescaled strobes and emits one `tick` per period.
- Supports periodic mode (auto-reload) and one-shot mode, with runtime period load, start and stop.

Parameters:
- PRESCALE, 50_000_000, clk cycles per prescaled strobe (ce); legal range 1 to 2^26.
- COUNT_W, 16, width of the period register and the down-counter.
- DEFAULT_PERIOD, 2, period in ce units after reset; must be 1 to 2^COUNT_W-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- start  input  1  level-sampled; begin or restart counting
- stop  input  1  level-sampled; abort counting and return to idle
- periodic  input  1  sampled only on an accepted start; 1 = auto-reload, 0 = one-shot
- load  input  1  write load_val into the period register
- load_val  input  COUNT_W  new period in ce units
- tick  output  1  registered one-cycle pulse at the end of each period
- busy  output  1  high while in RUN
- cnt_now  output  COUNT_W  current down-counter value (0 in IDLE)

Behaviour:
- Reset is sampled on the clk edge (rst=0) and overrides every other input. It sets:
  - state = IDLE, tick = 0, busy = 0, cnt = 0, pre = 0
  - period_reg = DEFAULT_PERIOD, mode_reg = 1
- Reset asserted mid-RUN aborts at that edge; no tick is produced.
- Registers:
  - pre: prescaler, 0 to PRESCALE-1.
  - cnt: down-counter, COUNT_W bits.
  - period_reg: period register.
  - mode_reg: latched copy of `periodic`.
- ce is combinational: ce = (state==RUN && pre==PRESCALE-1).
  - In RUN, pre increments every cycle and wraps to 0 when ce=1.
  - With PRESCALE=1, ce=1 on every RUN cycle.
- Period load:
  - When load=1 and load_val!=0, period_reg <= load_val.
  - load_val==0 is ignored; period_reg is held.
  - A load during RUN does not affect the current cnt. It takes effect at the next reload or start.
- State IDLE:
  - On start=1 and stop=0: go to RUN, pre <= 0, mode_reg <= periodic, busy <= 1.
  - cnt is loaded with the effective period: load_val if the same-cycle load is valid, otherwise period_reg.
- State RUN, on each ce:
  - If cnt > 1: cnt <= cnt-1.
  - If cnt == 1: tick <= 1 for exactly one cycle.
    - Periodic: cnt <= period_reg, pre wraps, remain in RUN.
    - One-shot: go to IDLE, busy <= 0, cnt <= 0; busy falls on the same edge tick rises.
- Timing:
  - Start accepted at edge S: tick is high in the cycle after edge S + PRESCALE*period.
  - Periodic ticks are then spaced exactly PRESCALE*period clk cycles apart.
- Inputs arriving while in RUN:
  - stop=1: go to IDLE at the next edge, cnt <= 0, pre <= 0, busy <= 0. A tick that would have been issued on that edge is suppressed.
  - start=1 (stop=0): restart. pre <= 0, cnt <= effective period, mode_reg re-sampled. Any pending terminal ce on that edge is discarded; no tick.
  - start and stop together: stop wins.
- tick is never high for two consecutive cycles, except in periodic mode with PRESCALE=1 and period=1, where tick is continuously high. That case is legal and must be verified.

Optional Feature:
- Macro: TICK_PULSE_GEN_TICK_COUNT_EN.
- Defined:
  - Adds output port tick_count (8 bits).
  - tick_count increments by 1 on every edge that sets tick=1, wrapping 255 to 0.
  - Cleared to 0 by reset and by any accepted start (from IDLE or restart).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- PRESCALE=4, reset release, load=1 with load_val=3, start pulse at edge S, periodic=1 -> tick high after edges S+12, S+24, S+36; busy=1 throughout; cnt_now sequence 3,2,1,3,...
- PRESCALE=4, period=2, periodic=0, start at S -> single tick after edge S+8; busy falls on the same edge; no further ticks over 40 cycles; cnt_now=0.
- PRESCALE=4, period=3, periodic, stop asserted at edge S+12 (terminal ce) -> no tick, state IDLE, busy=0. Start and stop together at a later edge -> stays IDLE.
- PRESCALE=4, period=3 running, load_val=5 at S+5 -> next tick still at S+12, following tick at S+32. load_val=0 at any time -> period unchanged.
- PRESCALE=1, period=1, periodic -> tick high every cycle from edge S+1. rst=0 mid-run -> tick=0, busy=0, cnt_now=0, and period restored to DEFAULT_PERIOD.
- With TICK_PULSE_GEN_TICK_COUNT_EN, PRESCALE=1, period=1, run 300 cycles -> tick_count wraps 255 to 0. Restart via start -> tick_count=0 on the next cycle.

Source files
------------

// File: rtl/tick_pulse_gen.sv
// tick_pulse_gen
//   Programmable timer that produces the single-cycle tick strobe for the LED
//   pattern logic. A prescaler divides clk into a clock-enable (ce). A
//   down-counter counts ce strobes and issues one tick at the end of each
//   period. The timer runs either periodic (auto-reload) or one-shot.
//
//   Ports:
//     clk        system clock
//     rst        synchronous reset, active-low
//     start      begin counting, or restart while running (level-sampled)
//     stop       abort counting and return to idle; wins over start
//     periodic   mode sampled on an accepted start: 1 = auto-reload, 0 = one-shot
//     load       write load_val into the period register (a zero value is ignored)
//     load_val   new period in ce units
//     tick       registered one-cycle pulse at the end of each period
//     busy       high while running
//     cnt_now    current down-counter value (0 when idle)
//     tick_count 8-bit wrapping tick counter, cleared on start
//                (present only when TICK_PULSE_GEN_TICK_COUNT_EN is defined)
//
//   Optional feature macro: TICK_PULSE_GEN_TICK_COUNT_EN
module tick_pulse_gen #(
    parameter int unsigned PRESCALE       = 50_000_000,
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned DEFAULT_PERIOD = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    output logic               tick,
    output logic               busy,
    output logic [COUNT_W-1:0] cnt_now
`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
    ,
    output logic [7:0]         tick_count
`endif
);

    // A one-bit prescaler is kept for PRESCALE=1; it simply sits at 0.
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [COUNT_W-1:0] PERIOD_RST = COUNT_W'(DEFAULT_PERIOD);
    localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] period_q, period_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;

    logic               ce;
    logic               load_ok;
    logic [COUNT_W-1:0] eff_period;
    logic               accept;     // start accepted this cycle (from IDLE or restart)

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        load_ok    = load && (load_val != '0);
        // A start in the same cycle as a valid load uses the new value at once.
        eff_period = load_ok ? load_val : period_q;
        ce         = (state_q == RUN) && (pre_q == PRE_MAX);

        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        period_d = load_ok ? load_val : period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    pre_d   = '0;
                    cnt_d   = eff_period;
                    mode_d  = periodic;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    // Stop beats both a restart and a terminal ce on this edge.
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end else if (start) begin
                    // Restart discards any terminal ce pending on this edge.
                    pre_d  = '0;
                    cnt_d  = eff_period;
                    mode_d = periodic;
                    accept = 1'b1;
                end else begin
                    pre_d = ce ? '0 : pre_q + 1'b1;
                    if (ce) begin
                        if (cnt_q > CNT_ONE) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            tick_d = 1'b1;
                            if (mode_q) begin
                                // Reload from the register so a load made
                                // mid-period takes effect here.
                                cnt_d = period_q;
                            end else begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            period_q <= PERIOD_RST;
            mode_q   <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign busy    = (state_q == RUN);
    assign cnt_now = cnt_q;

`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
    logic [7:0] tick_count_q, tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q;
        if (accept) begin
            tick_count_d = '0;
        end else if (tick_d) begin
            tick_count_d = tick_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_tick_pulse_gen.sv
// Directed testbench for tick_pulse_gen. Two instances share the stimulus:
// dut_a uses PRESCALE=4, dut_b uses PRESCALE=1. Whichever one is not under
// test is held in reset. Outputs are sampled 1 ns after each rising edge.
module tb_tick_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        start, stop, periodic, load;
    logic [15:0] load_val;
    logic        tick_a, busy_a, tick_b, busy_b;
    logic [15:0] cnt_a, cnt_b;
`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
    logic [7:0]  tc_a, tc_b;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    tick_pulse_gen #(.PRESCALE(4), .COUNT_W(16), .DEFAULT_PERIOD(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start), .stop(stop), .periodic(periodic),
        .load(load), .load_val(load_val), .tick(tick_a), .busy(busy_a), .cnt_now(cnt_a)
`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
        , .tick_count(tc_a)
`endif
    );

    tick_pulse_gen #(.PRESCALE(1), .COUNT_W(16), .DEFAULT_PERIOD(2)) dut_b (
        .clk(clk), .rst(rst_b), .start(start), .stop(stop), .periodic(periodic),
        .load(load), .load_val(load_val), .tick(tick_b), .busy(busy_b), .cnt_now(cnt_b)
`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
        , .tick_count(tc_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        start = 1'b0; stop = 1'b0; periodic = 1'b0; load = 1'b0; load_val = '0;
        step(2);
        check("a_rst_tick", tick_a, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_cnt",  cnt_a,  0);
        rst_a = 1'b1;
        step();

        // Periodic, period 3 loaded in the start cycle: ticks at S+12/24/36.
        load = 1'b1; load_val = 16'd3; periodic = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        check("p3_start_cnt",  cnt_a,  3);
        check("p3_start_busy", busy_a, 1);
        check("p3_start_tick", tick_a, 0);
        for (int k = 1; k <= 36; k++) begin
            step();
            check("p3_tick", tick_a, (k % 12) == 0);
            check("p3_busy", busy_a, 1);
            check("p3_cnt",  cnt_a,  3 - ((k / 4) % 3));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("p3_stop_busy", busy_a, 0);
        check("p3_stop_cnt",  cnt_a,  0);

        // One-shot, period 2 loaded while idle: single tick at S+8.
        load = 1'b1; load_val = 16'd2;
        step();
        load = 1'b0;
        check("os_idle_after_load", busy_a, 0);
        periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("os_start_cnt", cnt_a, 2);
        for (int k = 1; k <= 40; k++) begin
            step();
            check("os_tick", tick_a, k == 8);
            check("os_busy", busy_a, k < 8);
            check("os_cnt",  cnt_a,  (k < 8) ? (2 - k / 4) : 0);
        end

        // Stop on the terminal ce edge suppresses the tick.
        load = 1'b1; load_val = 16'd3; periodic = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        step(11);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_term_tick", tick_a, 0);
        check("stop_term_busy", busy_a, 0);
        check("stop_term_cnt",  cnt_a,  0);
        step(4);
        check("stop_later_tick", tick_a, 0);
        check("stop_later_busy", busy_a, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy_a, 0);
        check("start_stop_cnt",  cnt_a,  0);
        step(3);
        check("start_stop_tick", tick_a, 0);

        // Restart on the terminal ce edge discards that tick.
        start = 1'b1;
        step();
        start = 1'b0;
        step(11);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_tick", tick_a, 0);
        check("restart_cnt",  cnt_a,  3);
        check("restart_busy", busy_a, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("restart_next_tick", tick_a, k == 12);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Load of 5 at S+5 while running: ticks at S+12 then S+32.
        start = 1'b1; periodic = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            load = (k == 5); load_val = 16'd5;
            step();
            check("ld_tick", tick_a, (k == 12) || (k == 32));
            check("ld_cnt",  cnt_a,  (k < 12) ? (3 - k / 4) : (5 - ((k - 12) / 4) % 5));
        end
        load = 1'b0;

        // A zero load_val is ignored, both while running and in a start cycle.
        load = 1'b1; load_val = 16'd0;
        step();
        load = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b1; load = 1'b1; load_val = 16'd0;
        step();
        start = 1'b0; load = 1'b0;
        check("zero_load_cnt", cnt_a, 5);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // PRESCALE=1, period 1, periodic: tick held high from S+1.
        rst_a = 1'b0;
        check("b_rst_tick", tick_b, 0);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_cnt",  cnt_b,  0);
        rst_b = 1'b1;
        step();
        load = 1'b1; load_val = 16'd1; periodic = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        check("p1_start_tick", tick_b, 0);
        check("p1_start_cnt",  cnt_b,  1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("p1_tick", tick_b, 1);
            check("p1_cnt",  cnt_b,  1);
            check("p1_busy", busy_b, 1);
        end
        rst_b = 1'b0;
        step();
        check("p1_rst_tick", tick_b, 0);
        check("p1_rst_busy", busy_b, 0);
        check("p1_rst_cnt",  cnt_b,  0);
        rst_b = 1'b1;
        step();

        // After reset the period is back to 2: one-shot tick at S+2.
        periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("dflt_cnt", cnt_b, 2);
        step();
        check("dflt_k1_tick", tick_b, 0);
        check("dflt_k1_cnt",  cnt_b,  1);
        step();
        check("dflt_k2_tick", tick_b, 1);
        check("dflt_k2_busy", busy_b, 0);
        check("dflt_k2_cnt",  cnt_b,  0);
        step();
        check("dflt_k3_tick", tick_b, 0);

`ifdef TICK_PULSE_GEN_TICK_COUNT_EN
        // tick_count wraps 255 -> 0 and clears on restart.
        load = 1'b1; load_val = 16'd1; periodic = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        check("tc_start", tc_b, 0);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 255 || k == 256 || k == 300) begin
                check("tc_wrap", tc_b, k % 256);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("tc_restart",      tc_b,   0);
        check("tc_restart_tick", tick_b, 0);
        step();
        check("tc_after_restart", tc_b, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
